egg_timer_controller: RTL and testbench
=======================================

Name: egg_timer_controller

Overview:
- Top-level mode FSM of the egg timer.
- Sequences the user through clearing, setting seconds, setting minutes, ready, running and paused, driven by three push-button inputs.
- Exposes the current mode as a 4-bit STATE code for the datapath (time registers, countdown, display muxing).
- Purely control: no counters or time values inside.

Parameters:
- None. State encodings below are fixed constants.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- KEY  input  3  push buttons, 1 = pressed.
  - KEY[0]: reset, asynchronous, active-high.
  - KEY[1]: advance/set.
  - KEY[2]: start/pause.
- STATE  output  4  current FSM state code, driven directly from the state register.

Behaviour:
- State encoding:
  - RESET=4'b0000
  - SET_SEC=4'b0001
  - SET_MIN=4'b0010
  - READY=4'b0011
  - RUN=4'b0100
  - PAUSE=4'b0101
  - All other codes are illegal.
- Reset, KEY[0]=1:
  - Asynchronously forces STATE=RESET.
  - Sets both key-history registers to 1, so a key held across reset is not treated as a new press.
  - STATE holds RESET for as long as KEY[0] is high.
  - Applies mid-operation from any state.
- Press detection:
  - Per key (KEY[1], KEY[2]), a history register samples the key every rising CLK edge.
  - A press event is key==1 && history==0 at a rising edge.
  - Exactly one event per press, regardless of hold length; release generates nothing.
- Transitions, evaluated on the rising CLK edge with KEY[0]=0:
  - RESET -> SET_SEC unconditionally on the first edge after reset deasserts. Keys are ignored in RESET.
  - SET_SEC: KEY[1] press -> SET_MIN. KEY[2] ignored.
  - SET_MIN: KEY[1] press -> READY. KEY[2] ignored.
  - READY:
    - KEY[2] press -> RUN.
    - Else KEY[1] press -> SET_SEC (re-edit).
  - RUN: KEY[2] press -> PAUSE. KEY[1] ignored.
  - PAUSE:
    - KEY[2] press -> RUN.
    - Else KEY[1] press -> SET_SEC.
  - Illegal code -> RESET on the next edge.
- Simultaneous KEY[1] and KEY[2] press events in the same cycle: KEY[2] has priority wherever it is meaningful (READY, PAUSE, RUN). Otherwise the KEY[1] rule applies.
- Latency:
  - A press event changes STATE on the same edge that detects it.
  - No output changes occur between clock edges except via reset.
- There is no time-out/done input. RUN persists until a KEY[2] press or reset.
- Outputs are registered, glitch-free, and never X after the first reset.

Test Plan:
- Hold KEY[0]=1 for 10 cycles, release -> STATE=0000 while held; STATE=0001 (SET_SEC) one clock after release.
- From SET_SEC, assert KEY[1] for 10 cycles then release -> STATE=0010 after the first edge only; remains 0010 through the hold and the release.
- From SET_MIN, press KEY[1] again -> STATE=0011 (READY). Further KEY[2] presses in SET_SEC/SET_MIN leave STATE unchanged.
- READY: press KEY[2] -> 0100 (RUN); press KEY[2] -> 0101 (PAUSE); press KEY[2] -> 0100; KEY[1] while RUN -> stays 0100; KEY[1] while PAUSE -> 0001.
- Simultaneous KEY[1] and KEY[2] press in READY -> 0100. Hold KEY[1]=1 through reset and release reset -> no spurious SET_MIN; STATE 0000 -> 0001 and stays.
- Assert KEY[0] mid-cycle while in RUN -> STATE=0000 immediately, before the next clock edge.

Source files
------------

// File: rtl/egg_timer_controller_if.sv
// ---------------------------------------------------------------------------
// egg_timer_controller_if
//
// Purpose:
//   This bundle carries the push buttons into the egg timer mode FSM and the
//   mode code back out to the datapath.
//
// Signals:
//   key[2:0]   The push buttons, where 1 means pressed.
//              key[0] is an asynchronous active-high reset.
//              key[1] is advance/set.
//              key[2] is start/pause.
//   state[3:0] The current mode code, driven straight from the FSM register.
//
// Handshake:
//   There is no valid/ready pair. The buttons are level inputs that are
//   sampled on every rising clk edge. state is a registered level output,
//   so a consumer may sample it on any edge.
//
// Modports:
//   master  The button source and state consumer (the board or the bench).
//   slave   The controller itself.
// ---------------------------------------------------------------------------
interface egg_timer_controller_if;
    logic [2:0] key;
    logic [3:0] state;

    modport master (output key, input state);
    modport slave  (input key, output state);
endinterface

// File: rtl/egg_timer_controller.sv
// ---------------------------------------------------------------------------
// egg_timer_controller
//
// Purpose:
//   This is the top-level mode FSM of the egg timer. It steps the user through
//   the modes clear -> set seconds -> set minutes -> ready -> run/pause, using
//   two push buttons. It holds no counters and no time values. The 4-bit state
//   code tells the datapath what to do.
//
// Ports:
//   clk  The system clock. All state changes happen on its rising edge.
//   io   An egg_timer_controller_if slave.
//        io.key[0] is the asynchronous active-high reset.
//        io.key[1] is advance/set.
//        io.key[2] is start/pause.
//        io.state is the registered mode code, which doubles as the debug view.
//
// Mode codes:
//   RESET   = 0000
//   SET_SEC = 0001
//   SET_MIN = 0010
//   READY   = 0011
//   RUN     = 0100
//   PAUSE   = 0101
//   Any other code returns to RESET on the next edge.
// ---------------------------------------------------------------------------
module egg_timer_controller (
    input  logic                  clk,
    egg_timer_controller_if.slave io
);

    localparam logic [3:0] ST_RESET   = 4'b0000;
    localparam logic [3:0] ST_SET_SEC = 4'b0001;
    localparam logic [3:0] ST_SET_MIN = 4'b0010;
    localparam logic [3:0] ST_READY   = 4'b0011;
    localparam logic [3:0] ST_RUN     = 4'b0100;
    localparam logic [3:0] ST_PAUSE   = 4'b0101;

    logic       rst;
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       hist_adv;    // previous sample of key[1]
    logic       hist_start;  // previous sample of key[2]
    logic       press_adv;
    logic       press_start;

    assign rst = io.key[0];

    // A press is the rising edge of a button, seen on one clock only.
    // The history registers come out of reset as 1. Because of this, a button
    // held down across reset does not look like a fresh press afterwards.
    assign press_adv   = io.key[1] & ~hist_adv;
    assign press_start = io.key[2] & ~hist_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:   state_d = ST_SET_SEC;
            ST_SET_SEC: if (press_adv) state_d = ST_SET_MIN;
            ST_SET_MIN: if (press_adv) state_d = ST_READY;
            // In READY and PAUSE, start/pause takes priority over advance.
            ST_READY: begin
                if (press_start)    state_d = ST_RUN;
                else if (press_adv) state_d = ST_SET_SEC;
            end
            ST_RUN:     if (press_start) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (press_start)    state_d = ST_RUN;
                else if (press_adv) state_d = ST_SET_SEC;
            end
            default:    state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RESET;
            hist_adv   <= 1'b1;
            hist_start <= 1'b1;
        end else begin
            state_q    <= state_d;
            hist_adv   <= io.key[1];
            hist_start <= io.key[2];
        end
    end

    assign io.state = state_q;

endmodule

// File: tb/tb_egg_timer_controller.sv
// ---------------------------------------------------------------------------
// tb_egg_timer_controller
//
// Purpose:
//   This is a self-checking bench for egg_timer_controller.
//   The reference model describes the mode graph as two lookup tables:
//     - where the advance button leads from each mode;
//     - where the start button leads from each mode.
//   The model also keeps its own view of which buttons are currently held.
// ---------------------------------------------------------------------------
module tb_egg_timer_controller;

    logic clk;
    int   checks;
    int   errors;

    egg_timer_controller_if tbif ();

    egg_timer_controller dut (
        .clk (clk),
        .io  (tbif.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Mode numbers: 0 clear, 1 set sec, 2 set min, 3 ready, 4 run, 5 pause.
    int  adv_to   [6] = '{1, 2, 3, 1, 4, 1};  // destination on an advance press
    int  start_to [6] = '{1, 1, 2, 4, 5, 4};  // destination on a start press
    int  m_mode;
    bit  m_held_adv;
    bit  m_held_start;

    function automatic int model_next(input int mode, input bit p_adv, input bit p_start);
        if (mode == 0)                           return 1;  // clear always moves on
        if (p_start && start_to[mode] != mode)   return start_to[mode];
        if (p_adv)                               return adv_to[mode];
        return mode;
    endfunction

    // ---------------- driver tasks ----------------
    // This task runs one clock with the given buttons (and reset low), then
    // compares the DUT state against the model.
    task automatic cycle(input bit k_adv, input bit k_start, input string name);
        bit p_adv;
        bit p_start;
        @(negedge clk);
        tbif.key = {k_start, k_adv, 1'b0};
        @(posedge clk);
        p_adv        = k_adv && !m_held_adv;
        p_start      = k_start && !m_held_start;
        m_held_adv   = k_adv;
        m_held_start = k_start;
        m_mode       = model_next(m_mode, p_adv, p_start);
        #1;
        checks++;
        if (tbif.state !== 4'(m_mode)) begin
            errors++;
            $display("FAIL %s: state=%b expected=%b at %0t", name, tbif.state, 4'(m_mode), $time);
        end
    endtask

    // This task holds reset for n clocks while the other buttons sit at the
    // given levels. It checks that state stays at the clear mode throughout.
    task automatic hold_reset(input bit k_adv, input bit k_start, input int n);
        @(negedge clk);
        tbif.key     = {k_start, k_adv, 1'b1};
        m_mode       = 0;
        m_held_adv   = 1'b1;
        m_held_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tbif.state !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold: state=%b expected=0000 cycle %0d", tbif.state, i);
            end
        end
    endtask

    // This task presses a button for one clock and then releases it.
    task automatic press(input bit k_adv, input bit k_start, input string name);
        cycle(k_adv, k_start, name);
        cycle(1'b0, 1'b0, {name, "_release"});
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        hold_reset(1'b0, 1'b0, 10);
        cycle(1'b0, 1'b0, "reset_exit_set_sec");
        cycle(1'b0, 1'b0, "set_sec_idle");
    endtask

    task automatic test_adv_hold();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "adv_hold_set_min");
        cycle(1'b0, 1'b0, "adv_release_set_min");
        cycle(1'b0, 1'b0, "set_min_idle");
    endtask

    task automatic test_start_ignored_and_ready();
        press(1'b0, 1'b1, "start_in_set_min");
        press(1'b1, 1'b0, "adv_to_ready");
        hold_reset(1'b0, 1'b0, 2);
        cycle(1'b0, 1'b0, "reexit_set_sec");
        press(1'b0, 1'b1, "start_in_set_sec");
        press(1'b1, 1'b0, "adv_to_set_min");
        press(1'b1, 1'b0, "adv_to_ready2");
    endtask

    task automatic test_run_pause();
        press(1'b0, 1'b1, "ready_to_run");
        press(1'b0, 1'b1, "run_to_pause");
        press(1'b0, 1'b1, "pause_to_run");
        press(1'b1, 1'b0, "adv_in_run");
        press(1'b0, 1'b1, "run_to_pause2");
        press(1'b1, 1'b0, "pause_to_set_sec");
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0, "sim_set_min");
        press(1'b1, 1'b0, "sim_ready");
        press(1'b1, 1'b1, "both_in_ready");
        press(1'b0, 1'b1, "sim_pause");
        press(1'b1, 1'b1, "both_in_pause");
    endtask

    task automatic test_key_held_through_reset();
        hold_reset(1'b1, 1'b0, 4);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "adv_held_after_reset");
        cycle(1'b0, 1'b0, "adv_released_after_reset");
    endtask

    task automatic test_async_reset();
        press(1'b1, 1'b0, "ar_set_min");
        press(1'b1, 1'b0, "ar_ready");
        press(1'b0, 1'b1, "ar_run");
        @(posedge clk);
        #3;
        tbif.key[0] = 1'b1;
        #1;
        checks++;
        if (tbif.state !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: state=%b expected=0000 before edge", tbif.state);
        end
        hold_reset(1'b0, 1'b0, 2);
        cycle(1'b0, 1'b0, "ar_exit");
    endtask

    task automatic test_random();
        bit k_adv;
        bit k_start;
        k_adv   = 1'b0;
        k_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                hold_reset(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                           int'($urandom_range(1, 3)));
            end
            // Buttons tend to stay where they are, to give a mix of long and short holds.
            if ($urandom_range(0, 2) == 0) k_adv   = ~k_adv;
            if ($urandom_range(0, 2) == 0) k_start = ~k_start;
            cycle(k_adv, k_start, "random");
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks       = 0;
        errors       = 0;
        tbif.key     = 3'b001;
        m_mode       = 0;
        m_held_adv   = 1'b1;
        m_held_start = 1'b1;

        test_reset();
        test_adv_hold();
        test_start_ignored_and_ready();
        test_run_pause();
        test_simultaneous();
        test_key_held_through_reset();
        test_async_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
